mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch port and the data load/store port of the MIPS core.
- Each requester gets a request/grant acceptance handshake and a one-cycle ready completion pulse.
- Sits between the core and the memory and turns two concurrent requesters into serialised, fixed-latency memory transactions.
- Ties between the two requesters are broken fairly by alternating the winner.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/arb2_fair.sv | 15 +
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb2_fair.sv
// Two-way combinational arbiter; a tie goes to whoever did not win last.
module arb2_fair
  import mem_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  assign valid  = i_req | d_req;
  assign winner = (i_req && d_req) ? ~last_owner : (d_req ? OWN_D : OWN_I);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-port memory
// with a fixed access latency and per-port grant/ready handshakes.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e              state_q;
  logic                owner_q;
  logic                last_owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic arb_valid;
  logic arb_winner;

  arb2_fair u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            owner_q      <= arb_winner;
            last_owner_q <= arb_winner;
            cnt_q        <= CNT_INIT;
            state_q      <= S_ACCESS;
            if (arb_winner == OWN_D) begin
              addr_q  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_wdata;
            end else begin
              addr_q  <= i_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Read data is only guaranteed valid in the final access cycle.
            if (!we_q) begin
              if (owner_q == OWN_D) d_rdata_q <= mem_rdata;
              else                  i_rdata_q <= mem_rdata;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        i_gnt = arb_valid && (arb_winner == OWN_I);
        d_gnt = arb_valid && (arb_winner == OWN_D);
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      S_RESP: begin
        i_ready = (owner_q == OWN_I);
        d_ready = (owner_q == OWN_D);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random-stimulus bench: two arbiters (MEM_LAT=2 and MEM_LAT=1) checked every
// cycle against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_gnt [2], i_ready [2], d_gnt [2], d_ready [2];
  logic        mem_en [2], mem_we [2], busy [2];
  logic [31:0] i_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_ready(i_ready[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[0]), .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_ready(i_ready[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt[1]), .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference model: a transaction is a grant cycle plus a fixed timeline
  // (access for lat cycles, then one response cycle).
  int          lat [2] = '{2, 1};
  bit          act [2];
  int          start [2];
  bit          own [2];
  bit          last [2];
  logic [31:0] addr_m [2], wd_m [2], ird_m [2], drd_m [2];
  bit          we_m [2];
  int          cyc;

  initial begin
    bit    vld, w, in_acc, in_resp;
    int    ph;
    string p;

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata[0] = '0; mem_rdata[1] = '0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; last[k] = 1'b0; ird_m[k] = '0; drd_m[k] = '0;
      start[k] = 0; own[k] = 1'b0; we_m[k] = 1'b0; addr_m[k] = '0; wd_m[k] = '0;
    end
    cyc = 0;
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      rst = (c > 5) && ($urandom_range(0, 59) == 0);
      if (c == 0) begin
        i_req = 1'b0; d_req = 1'b0;
      end else if (c == 1) begin
        i_req = 1'b1; d_req = 1'b1;
      end else begin
        i_req = ($urandom_range(0, 3) != 0);
        d_req = ($urandom_range(0, 3) != 0);
      end
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      mem_rdata[0] = $urandom;
      mem_rdata[1] = $urandom;
      #3;

      vld = i_req | d_req;
      w   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        p  = $sformatf("L%0d c%0d", lat[k], c);
        w  = (i_req && d_req) ? !last[k] : d_req;
        ph = cyc - start[k];
        in_acc  = act[k] && (ph >= 1) && (ph <= lat[k]);
        in_resp = act[k] && (ph == lat[k] + 1);

        chk({p, " i_gnt"},   32'(i_gnt[k]),   32'(!act[k] && vld && !w));
        chk({p, " d_gnt"},   32'(d_gnt[k]),   32'(!act[k] && vld && w));
        chk({p, " i_ready"}, 32'(i_ready[k]), 32'(in_resp && !own[k]));
        chk({p, " d_ready"}, 32'(d_ready[k]), 32'(in_resp && own[k]));
        chk({p, " busy"},    32'(busy[k]),    32'(act[k]));
        chk({p, " mem_en"},  32'(mem_en[k]),  32'(in_acc));
        chk({p, " mem_we"},  32'(mem_we[k]),  32'(in_acc && we_m[k]));
        chk({p, " mem_addr"}, mem_addr[k], in_acc ? addr_m[k] : 32'h0);
        if (!in_acc || own[k])
          chk({p, " mem_wdata"}, mem_wdata[k], in_acc ? wd_m[k] : 32'h0);
        chk({p, " i_rdata"}, i_rdata[k], ird_m[k]);
        chk({p, " d_rdata"}, d_rdata[k], drd_m[k]);

        if (rst) begin
          act[k] = 1'b0; last[k] = 1'b0; ird_m[k] = '0; drd_m[k] = '0;
        end else if (!act[k]) begin
          if (vld) begin
            act[k] = 1'b1; start[k] = cyc; own[k] = w; last[k] = w;
            if (w) begin
              addr_m[k] = d_addr; we_m[k] = d_we; wd_m[k] = d_wdata;
            end else begin
              addr_m[k] = i_addr; we_m[k] = 1'b0; wd_m[k] = '0;
            end
          end
        end else begin
          if (ph == lat[k] && !we_m[k]) begin
            if (own[k]) drd_m[k] = mem_rdata[k];
            else        ird_m[k] = mem_rdata[k];
          end
          if (ph == lat[k] + 1) act[k] = 1'b0;
        end
      end
      cyc++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
